// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
package sram_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 20;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned CLIENT_REC = 0;
    localparam int unsigned CLIENT_PLY = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_e;

    function automatic logic [1:0] client_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker; the pointer moves past the winner on each accepted grant.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    // ptr_q=1 favours client 1, so a client-0 win hands priority to client 1
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && (grant_o != 2'b00)) begin
            ptr_d = grant_o[0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async 16-bit SRAM between recorder and player; owns all SRAM pin timing.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_req,
    input  logic [1:0]            i_we,
    input  logic [2*ADDR_W-1:0]   i_addr,
    input  logic [2*DATA_W-1:0]   i_wdata,
    output logic [1:0]            o_ack,
    output logic [1:0]            o_rvalid,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_busy,
    inout  wire  [DATA_W-1:0]     SRAM_DQ,
    output logic [ADDR_W-1:0]     SRAM_ADDR,
    output logic                  SRAM_OE_N,
    output logic                  SRAM_WE_N,
    output logic                  SRAM_CE_N,
    output logic                  SRAM_UB_N,
    output logic                  SRAM_LB_N
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                owner_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rvalid_q;
    logic                drive_q;
    logic                ce_n_q;
    logic                oe_n_q;
    logic                we_n_q;

    logic [1:0]          grant;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    rr_arbiter2 u_rr (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .req_i     (i_req),
        .advance_i (state_q == IDLE),
        .grant_o   (grant)
    );

    always_comb begin
        win_we    = grant[CLIENT_PLY] ? i_we[CLIENT_PLY] : i_we[CLIENT_REC];
        win_addr  = grant[CLIENT_PLY] ? i_addr[2*ADDR_W-1:ADDR_W] : i_addr[ADDR_W-1:0];
        win_wdata = grant[CLIENT_PLY] ? i_wdata[2*DATA_W-1:DATA_W] : i_wdata[DATA_W-1:0];
    end

    assign o_ack = (state_q == IDLE) ? grant : 2'b00;

    // Strobes are registered and set on the transition into each state, so they
    // line up with state_q without decode glitches on the SRAM pins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            owner_q  <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= '0;
            drive_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
        end else begin
            rvalid_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (grant != 2'b00) begin
                        state_q <= ACCESS;
                        cnt_q   <= '0;
                        addr_q  <= win_addr;
                        we_q    <= win_we;
                        wdata_q <= win_wdata;
                        owner_q <= grant[CLIENT_PLY];
                        ce_n_q  <= 1'b0;
                        oe_n_q  <= win_we;
                        we_n_q  <= ~win_we;
                        drive_q <= win_we;
                    end
                end
                ACCESS: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= RECOVER;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        if (!we_q) begin
                            rdata_q  <= SRAM_DQ;
                            rvalid_q <= client_onehot(owner_q);
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RECOVER: begin
                    // write data stays on DQ here to cover hold time after WE_N rises
                    state_q <= IDLE;
                    ce_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SRAM_DQ   = drive_q ? wdata_q : 'z;
    assign SRAM_ADDR = addr_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_UB_N = ce_n_q;
    assign SRAM_LB_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;
    assign o_rdata   = rdata_q;
    assign o_rvalid  = rvalid_q;
    assign o_busy    = (state_q != IDLE);

endmodule
